// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS-lite datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB as needed.
// The state register is the only storage. Every control output is decoded
// combinationally from the state, the instruction register, zero and mem_ready.
module mc_ctrl #(
    parameter int ALU_CTL_W = 4,    // width of alu_ctl, at least 3 so lui (5) fits
    parameter bit EXT_ISA   = 1'b1  // 1: addiu/jal/jr are legal, 0: they trap
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic [1:0]           npc_sel,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wd_sel,
    output logic                 alu_src,
    output logic                 ext_op,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 illegal,
    output logic [2:0]           state
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------

    // Primary opcodes and R-type function codes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;

    // Next-PC source
    localparam logic [1:0] NPC_SEQ    = 2'd0;  // PC+4
    localparam logic [1:0] NPC_BRANCH = 2'd1;  // PC+4 + (simm << 2)
    localparam logic [1:0] NPC_JUMP   = 2'd2;  // {PC[31:28], target, 2'b00}
    localparam logic [1:0] NPC_REG    = 2'd3;  // rs

    // Register-file destination
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;      // $31

    // Register-file write data
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    // ALU operations
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(0);
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = ALU_CTL_W'(1);
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = ALU_CTL_W'(3);
    localparam logic [ALU_CTL_W-1:0] ALU_CMP = ALU_CTL_W'(4);
    localparam logic [ALU_CTL_W-1:0] ALU_LUI = ALU_CTL_W'(5);

    // Sequencer states. Codes 5 and 6 are unused and recover into TRAP.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    // Decoded instruction class
    typedef enum logic [3:0] {
        I_NOP,
        I_ADDU,
        I_SUBU,
        I_ORI,
        I_LW,
        I_SW,
        I_BEQ,
        I_LUI,
        I_J,
        I_ADDIU,
        I_JAL,
        I_JR,
        I_ILLEGAL
    } instr_t;

    state_t                 state_q;
    state_t                 state_n;
    instr_t                 instr;

    logic [5:0]             opcode;
    logic [5:0]             funct;

    // EXEC-phase ALU setup, reused unchanged through MEM
    logic                   ex_alu_src;
    logic                   ex_ext_op;
    logic [ALU_CTL_W-1:0]   ex_alu_ctl;

    // WB-phase destination and data source
    logic [1:0]             wb_dst;
    logic [1:0]             wb_wd;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------

    // Classify the IR contents; extended opcodes are legal only with EXT_ISA.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path can leave one holding its old value and infer a latch.
        instr = I_ILLEGAL;
        if (instruction == 32'd0) begin
            instr = I_NOP;
        end else begin
            case (opcode)
                OPC_RTYPE: begin
                    case (funct)
                        FN_ADDU: instr = I_ADDU;
                        FN_SUBU: instr = I_SUBU;
                        FN_JR:   if (EXT_ISA) instr = I_JR;
                        default: instr = I_ILLEGAL;
                    endcase
                end
                OPC_ORI:   instr = I_ORI;
                OPC_LW:    instr = I_LW;
                OPC_SW:    instr = I_SW;
                OPC_BEQ:   instr = I_BEQ;
                OPC_LUI:   instr = I_LUI;
                OPC_J:     instr = I_J;
                OPC_ADDIU: if (EXT_ISA) instr = I_ADDIU;
                OPC_JAL:   if (EXT_ISA) instr = I_JAL;
                default:   instr = I_ILLEGAL;
            endcase
        end
    end

    // ALU operand/operation per instruction; logical immediates zero-extend.
    always_comb begin
        ex_alu_src = 1'b0;
        ex_ext_op  = 1'b0;
        ex_alu_ctl = ALU_ADD;
        case (instr)
            I_ADDU:  ex_alu_ctl = ALU_ADD;
            I_SUBU:  ex_alu_ctl = ALU_SUB;
            I_ORI: begin
                ex_alu_src = 1'b1;
                ex_alu_ctl = ALU_OR;
            end
            I_LUI: begin
                ex_alu_src = 1'b1;
                ex_alu_ctl = ALU_LUI;
            end
            I_LW, I_SW, I_ADDIU: begin
                ex_alu_src = 1'b1;
                ex_ext_op  = 1'b1;
                ex_alu_ctl = ALU_ADD;
            end
            I_BEQ: begin
                ex_ext_op  = 1'b1;
                ex_alu_ctl = ALU_CMP;
            end
            default: ex_alu_ctl = ALU_ADD;
        endcase
    end

    // Write-back routing: loads take memory data, R-type targets rd.
    always_comb begin
        wb_dst = DST_RT;
        wb_wd  = WD_ALU;
        case (instr)
            I_ADDU, I_SUBU: wb_dst = DST_RD;
            I_LW:           wb_wd  = WD_MEM;
            default: begin
                wb_dst = DST_RT;
                wb_wd  = WD_ALU;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // State register; reset overrides every transition, including TRAP.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so the register takes the pre-edge next state,
        // independent of evaluation order against other clocked logic.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and all datapath controls; reset forces every output low.
    always_comb begin
        state_n   = state_q;
        pc_write  = 1'b0;
        npc_sel   = NPC_SEQ;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        alu_src   = 1'b0;
        ext_op    = 1'b0;
        alu_ctl   = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        state     = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    npc_sel  = NPC_SEQ;
                    state_n  = S_DECODE;
                end
            end

            S_DECODE: begin
                case (instr)
                    I_J: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_JUMP;
                        state_n  = S_FETCH;
                    end
                    I_JAL: begin
                        pc_write  = 1'b1;
                        npc_sel   = NPC_JUMP;
                        reg_write = 1'b1;
                        reg_dst   = DST_RA;
                        wd_sel    = WD_PC4;
                        state_n   = S_FETCH;
                    end
                    I_JR: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_REG;
                        state_n  = S_FETCH;
                    end
                    I_NOP:     state_n = S_FETCH;
                    I_ILLEGAL: state_n = S_TRAP;
                    default:   state_n = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_src = ex_alu_src;
                ext_op  = ex_ext_op;
                alu_ctl = ex_alu_ctl;
                if (instr == I_BEQ) begin
                    // The branch resolves here and only here.
                    pc_write = zero;
                    npc_sel  = NPC_BRANCH;
                    state_n  = S_FETCH;
                end else if (instr == I_LW || instr == I_SW) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end

            S_MEM: begin
                // Address operands stay put while memory is busy.
                alu_src   = ex_alu_src;
                ext_op    = ex_ext_op;
                alu_ctl   = ex_alu_ctl;
                mem_read  = (instr == I_LW);
                mem_write = (instr == I_SW);
                if (mem_ready) begin
                    state_n = (instr == I_LW) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = wb_dst;
                wd_sel    = wb_wd;
                state_n   = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
                state_n = S_TRAP;
            end

            default: state_n = S_TRAP;
        endcase

        // Reset abandons whatever is in flight: no strobe, no write.
        if (rst) begin
            state_n   = S_FETCH;
            pc_write  = 1'b0;
            npc_sel   = NPC_SEQ;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            reg_dst   = DST_RT;
            wd_sel    = WD_ALU;
            alu_src   = 1'b0;
            ext_op    = 1'b0;
            alu_ctl   = ALU_ADD;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
            state     = 3'd0;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------

    // A single memory port never reads and writes in the same cycle.
    a_mem_exclusive : assert property (@(posedge clk) !(mem_read && mem_write));

    // An instruction fetch always advances the PC sequentially.
    a_fetch_advances : assert property (@(posedge clk)
        ir_write |-> (pc_write && npc_sel == NPC_SEQ));

    // A trapped sequencer drives no enables or strobes.
    a_trap_quiet : assert property (@(posedge clk)
        illegal |-> !(pc_write || ir_write || reg_write || mem_read || mem_write));

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. The driver pushes an
// instruction-level summary of expected behaviour; a monitor folds the DUT's
// per-cycle outputs into the same summary and compares at instruction end.
module tb_mc_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic          zero;
    logic          mem_ready;

    // Extended-ISA DUT
    logic          pc_write;
    logic [1:0]    npc_sel;
    logic          ir_write;
    logic          reg_write;
    logic [1:0]    reg_dst;
    logic [1:0]    wd_sel;
    logic          alu_src;
    logic          ext_op;
    logic [AW-1:0] alu_ctl;
    logic          mem_read;
    logic          mem_write;
    logic          illegal;
    logic [2:0]    state;

    // Base-ISA DUT, same inputs
    logic          b_pc_write;
    logic [1:0]    b_npc_sel;
    logic          b_ir_write;
    logic          b_reg_write;
    logic [1:0]    b_reg_dst;
    logic [1:0]    b_wd_sel;
    logic          b_alu_src;
    logic          b_ext_op;
    logic [2:0]    b_alu_ctl;
    logic          b_mem_read;
    logic          b_mem_write;
    logic          b_illegal;
    logic [2:0]    b_state;

    mc_ctrl #(.ALU_CTL_W(AW), .EXT_ISA(1'b1)) u_dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .npc_sel(npc_sel),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op), .alu_ctl(alu_ctl),
        .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal),
        .state(state)
    );

    mc_ctrl #(.ALU_CTL_W(3), .EXT_ISA(1'b0)) u_dut_base (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .pc_write(b_pc_write), .npc_sel(b_npc_sel),
        .ir_write(b_ir_write), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .wd_sel(b_wd_sel), .alu_src(b_alu_src), .ext_op(b_ext_op),
        .alu_ctl(b_alu_ctl), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .illegal(b_illegal), .state(b_state)
    );

    always #5 clk = ~clk;

    wire [20:0] out_vec = {pc_write, npc_sel, ir_write, reg_write, reg_dst, wd_sel,
                           alu_src, ext_op, alu_ctl, mem_read, mem_write, illegal, state};
    wire [19:0] b_out_vec = {b_pc_write, b_npc_sel, b_ir_write, b_reg_write, b_reg_dst,
                             b_wd_sel, b_alu_src, b_ext_op, b_alu_ctl, b_mem_read,
                             b_mem_write, b_illegal, b_state};
    wire [4:0]  en_vec   = {pc_write, ir_write, reg_write, mem_read, mem_write};
    wire [4:0]  b_en_vec = {b_pc_write, b_ir_write, b_reg_write, b_mem_read, b_mem_write};

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_ADDIU, K_JAL, K_JR, K_NOP
    } kind_e;

    // What one instruction does, seen from outside the controller.
    typedef struct {
        int         cycles;   // FETCH entry to next FETCH entry
        int         ir_cnt;   // IR loads
        int         pc_cnt;   // PC loads
        logic [7:0] pc_log;   // npc_sel of each PC load, oldest in the high bits
        int         rw_cnt;   // register-file writes
        logic [1:0] rw_dst;
        logic [1:0] rw_wd;
        int         mr_cnt;   // cycles with mem_read
        int         mw_cnt;   // cycles with mem_write
        logic [3:0] ex_alu;   // ALU setup seen in EXEC (0 if no EXEC)
        logic       ex_src;
        logic       ex_ext;
        logic       hold_bad; // ALU setup changed between EXEC and MEM
        logic       bad;      // illegal raised or read+write together
    } summ_t;

    summ_t exp_q[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    // Reference: instruction-level effects from the ISA tables and timing rules.
    function automatic summ_t model(input kind_e k, input int wf, input int wm, input logic z);
        summ_t s;
        bit    is_mem;
        s      = '{default: 0};
        is_mem = (k == K_LW) || (k == K_SW);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI, K_ADDIU: s.cycles = 4;
            K_LW:    s.cycles = 5;
            K_SW:    s.cycles = 4;
            K_BEQ:   s.cycles = 3;
            default: s.cycles = 2;
        endcase
        s.cycles += wf + (is_mem ? wm : 0);
        s.ir_cnt  = 1;
        s.pc_cnt  = 1;
        s.pc_log  = 8'h00;
        case (k)
            K_J, K_JAL: begin s.pc_cnt = 2; s.pc_log = 8'h02; end
            K_JR:       begin s.pc_cnt = 2; s.pc_log = 8'h03; end
            K_BEQ:      if (z) begin s.pc_cnt = 2; s.pc_log = 8'h01; end
            default: ;
        endcase
        case (k)
            K_ADDU, K_SUBU:       begin s.rw_cnt = 1; s.rw_dst = 2'd1; s.rw_wd = 2'd0; end
            K_ORI, K_LUI, K_ADDIU: begin s.rw_cnt = 1; s.rw_dst = 2'd0; s.rw_wd = 2'd0; end
            K_LW:                 begin s.rw_cnt = 1; s.rw_dst = 2'd0; s.rw_wd = 2'd1; end
            K_JAL:                begin s.rw_cnt = 1; s.rw_dst = 2'd2; s.rw_wd = 2'd2; end
            default: ;
        endcase
        s.mr_cnt = wf + 1 + ((k == K_LW) ? wm + 1 : 0);
        s.mw_cnt = (k == K_SW) ? wm + 1 : 0;
        case (k)
            K_SUBU:  s.ex_alu = 4'd1;
            K_ORI:   s.ex_alu = 4'd3;
            K_BEQ:   s.ex_alu = 4'd4;
            K_LUI:   s.ex_alu = 4'd5;
            default: s.ex_alu = 4'd0;
        endcase
        s.ex_src = (k == K_ORI) || (k == K_LW) || (k == K_SW) || (k == K_LUI) || (k == K_ADDIU);
        s.ex_ext = (k == K_LW) || (k == K_SW) || (k == K_BEQ) || (k == K_ADDIU);
        return s;
    endfunction

    // Random instruction word of a given kind; register/immediate fields are noise.
    function automatic logic [31:0] encode(input kind_e k);
        logic [25:0] r;
        r = 26'($urandom);
        case (k)
            K_ADDU:  return {6'h00, r[25:6], 6'h21};
            K_SUBU:  return {6'h00, r[25:6], 6'h23};
            K_JR:    return {6'h00, r[25:6], 6'h08};
            K_ORI:   return {6'h0d, r};
            K_LW:    return {6'h23, r};
            K_SW:    return {6'h2b, r};
            K_BEQ:   return {6'h04, r};
            K_LUI:   return {6'h0f, r};
            K_J:     return {6'h02, r};
            K_ADDIU: return {6'h09, r};
            K_JAL:   return {6'h03, r};
            default: return 32'h0;
        endcase
    endfunction

    // Drive one instruction: wf fetch stalls, wm memory stalls, zero=z in EXEC.
    // Inputs that should not matter in a given cycle are randomized.
    task automatic run_instr(input kind_e k, input logic [31:0] word,
                             input int wf, input int wm, input logic z);
        summ_t e;
        bit    is_mem;
        int    ms;
        e      = model(k, wf, wm, z);
        is_mem = (k == K_LW) || (k == K_SW);
        ms     = wf + 3;
        exp_q.push_back(e);
        for (int c = 0; c < e.cycles; c++) begin
            if (c == wf + 1) instruction = word;
            if (c < wf)                                  mem_ready = 1'b0;
            else if (c == wf)                            mem_ready = 1'b1;
            else if (is_mem && c >= ms && c < ms + wm)   mem_ready = 1'b0;
            else if (is_mem && c == ms + wm)             mem_ready = 1'b1;
            else                                         mem_ready = 1'($urandom);
            zero = (c == wf + 2) ? z : 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare(input summ_t a, input int idx);
        summ_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow idx=%0d got=instruction expected=none", idx);
            return;
        end
        e = exp_q.pop_front();
        check("cycles",   idx, a.cycles,   e.cycles);
        check("ir_cnt",   idx, a.ir_cnt,   e.ir_cnt);
        check("pc_cnt",   idx, a.pc_cnt,   e.pc_cnt);
        check("pc_log",   idx, a.pc_log,   e.pc_log);
        check("rw_cnt",   idx, a.rw_cnt,   e.rw_cnt);
        check("rw_dst",   idx, a.rw_dst,   e.rw_dst);
        check("rw_wd",    idx, a.rw_wd,    e.rw_wd);
        check("mr_cnt",   idx, a.mr_cnt,   e.mr_cnt);
        check("mw_cnt",   idx, a.mw_cnt,   e.mw_cnt);
        check("ex_alu",   idx, a.ex_alu,   e.ex_alu);
        check("ex_src",   idx, a.ex_src,   e.ex_src);
        check("ex_ext",   idx, a.ex_ext,   e.ex_ext);
        check("hold_bad", idx, a.hold_bad, e.hold_bad);
        check("bad",      idx, a.bad,      e.bad);
    endtask

    // Monitor: an instruction ends when the DUT re-enters FETCH.
    task automatic monitor();
        summ_t      acc;
        bit         in_txn = 1'b0;
        logic [2:0] prev   = 3'd7;
        int         idx    = 0;
        acc = '{default: 0};
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                in_txn = 1'b0;
                prev   = 3'd7;
                continue;
            end
            if (state == 3'd0 && prev != 3'd0) begin
                if (in_txn) begin
                    compare(acc, idx);
                    idx++;
                end
                in_txn = 1'b1;
                acc    = '{default: 0};
            end
            if (in_txn) begin
                acc.cycles++;
                if (ir_write) acc.ir_cnt++;
                if (pc_write) begin
                    acc.pc_cnt++;
                    acc.pc_log = {acc.pc_log[5:0], npc_sel};
                end
                if (reg_write) begin
                    acc.rw_cnt++;
                    acc.rw_dst = reg_dst;
                    acc.rw_wd  = wd_sel;
                end
                if (mem_read)  acc.mr_cnt++;
                if (mem_write) acc.mw_cnt++;
                if (state == 3'd2) begin
                    acc.ex_alu = alu_ctl;
                    acc.ex_src = alu_src;
                    acc.ex_ext = ext_op;
                end
                if (state == 3'd3 && (alu_ctl != acc.ex_alu || alu_src != acc.ex_src ||
                                      ext_op != acc.ex_ext))
                    acc.hold_bad = 1'b1;
                if (illegal || (mem_read && mem_write)) acc.bad = 1'b1;
            end
            prev = state;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Fetch `word`, expect DECODE then TRAP on the chosen DUT, hold, then reset out.
    task automatic trap_seq(input logic [31:0] word, input bit use_base);
        reset_pulse();
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        instruction = word;
        @(negedge clk);
        check("trap_decode", 0, use_base ? b_state : state, 3'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("trap_enter", 0, use_base ? {b_illegal, b_state} : {illegal, state}, 4'hf);
        if (use_base) check("ext_addiu_exec", 0, state, 3'd2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            @(negedge clk);
            check("trap_hold", i, use_base ? {b_illegal, b_state, b_en_vec} : {illegal, state, en_vec},
                  {1'b1, 3'd7, 5'd0});
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("trap_rst_force", 0, use_base ? 32'(b_out_vec) : 32'(out_vec), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("trap_rst_exit", 0, use_base ? {b_illegal, b_state} : {illegal, state}, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog idx=0 got=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        kind_e k;
        int    wf;
        int    wm;

        rst         = 1'b1;
        mem_ready   = 1'b1;
        zero        = 1'b0;
        instruction = 32'h0;

        fork
            monitor();
        join_none

        // Reset: two edges with rst high, then release with memory ready.
        #1;
        check("rst_out_pre", 0, out_vec, 21'd0);
        @(negedge clk);
        check("rst_out_edge1", 0, out_vec, 21'd0);
        check("rst_state", 0, state, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_fetch", 0, {mem_read, ir_write, pc_write, npc_sel}, 5'b11100);
        @(posedge clk);
        #1;

        // Scoreboard phase: directed sequence, then random traffic.
        reset_pulse();
        sb_en = 1'b1;
        run_instr(K_ADDU, 32'h00851021, 0, 0, 1'b0);
        run_instr(K_ORI,  32'h34a5ffff, 0, 0, 1'b0);
        run_instr(K_LW,   32'h8c880004, 0, 0, 1'b0);
        run_instr(K_SW,   32'hac880008, 0, 0, 1'b0);
        run_instr(K_BEQ,  32'h10850003, 0, 0, 1'b1);
        run_instr(K_BEQ,  32'h10850003, 0, 0, 1'b0);
        run_instr(K_JAL,  32'h0c000010, 0, 0, 1'b0);
        run_instr(K_JR,   32'h03e00008, 0, 0, 1'b0);
        run_instr(K_LW,   32'h8c880004, 3, 2, 1'b0);
        run_instr(K_NOP,  32'h00000000, 1, 0, 1'b0);
        run_instr(K_ADDIU, 32'h24420001, 0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            k  = kind_e'($urandom_range(0, 11));
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_instr(k, encode(k), wf, wm, 1'($urandom));
        end
        // One stalled FETCH cycle lets the monitor close the last instruction.
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        sb_en = 1'b0;
        check("sb_drain", 0, exp_q.size(), 0);

        // Illegal opcode on the extended DUT; addiu on the base DUT.
        trap_seq(32'hfc000000, 1'b0);
        trap_seq(32'h24420001, 1'b1);

        // Reset while sw waits in MEM.
        reset_pulse();
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        instruction = 32'hac880008;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sw_mem_wait", 0, {state, mem_write}, {3'd3, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("sw_rst_drop", 0, out_vec, 21'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("sw_rst_fetch", 0, {state, mem_read, mem_write}, {3'd0, 1'b1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-lite datapath, replacing single-cycle decode with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath's register, ALU, memory and next-PC controls from the instruction register contents and a memory-ready handshake. A parameter enables an extended ISA: `addiu`, `jal`, `jr`. Illegal opcodes trap and halt the sequencer.

## Interface
- `ALU_CTL_W`, 4: width of `alu_ctl`; must be ≥ 3.
- `EXT_ISA`, 1: 1 enables `addiu`/`jal`/`jr`; 0 treats them as illegal.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instruction`  in  32  current instruction-register contents.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  PC load enable.
- `npc_sel`  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs register.
- `ir_write`  out  1  instruction-register load enable.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  2  destination: 0 = rt, 1 = rd, 2 = $31.
- `wd_sel`  out  2  write data: 0 = ALU, 1 = memory, 2 = PC+4.
- `alu_src`  out  1  ALU B operand: 0 = rt, 1 = extended immediate.
- `ext_op`  out  1  1 = sign-extend, 0 = zero-extend.
- `alu_ctl`  out  `ALU_CTL_W`  ALU operation: 0 add, 1 sub, 3 or, 4 compare-sub, 5 lui.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `illegal`  out  1  sticky trap flag.
- `state`  out  3  current FSM state, for debug and verification.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Only the state register is sequential. All other outputs are combinational from `state`, the decoded `instruction`, `zero` and `mem_ready`.
- **Decoded instructions:**
  - `addu` (op 0x00, funct 0x21), `subu` (0x00, 0x23)
  - `ori` 0x0d, `lw` 0x23, `sw` 0x2b, `beq` 0x04, `lui` 0x0f, `j` 0x02
  - with EXT_ISA: `addiu` 0x09, `jal` 0x03, `jr` (0x00, funct 0x08)
  - The all-zero word is `nop`.
  - Anything else is illegal.
- **FETCH:**
  - Drives `mem_read`=1.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1 with `npc_sel`=0, and the next state is DECODE.
  - Otherwise the FSM holds in FETCH.
- **DECODE:**
  - `j`: `pc_write`=1, `npc_sel`=2, next state FETCH.
  - `jal`: same as `j`, plus `reg_write`=1, `reg_dst`=2, `wd_sel`=2.
  - `jr`: `pc_write`=1, `npc_sel`=3, next state FETCH.
  - `nop`: next state FETCH.
  - Illegal: next state TRAP.
  - All other instructions: next state EXEC.
- **EXEC:**
  - Outputs `alu_src` and `alu_ctl` per instruction.
  - `ext_op`=1 for `lw`/`sw`/`beq`/`addiu`; 0 otherwise.
  - `beq`: `alu_ctl`=4, `pc_write`=`zero`, `npc_sel`=1, next state FETCH.
  - `lw`/`sw`: next state MEM.
  - Others: next state WB.
- **MEM:**
  - `lw`: `mem_read`=1. `sw`: `mem_write`=1.
  - `alu_src`, `alu_ctl` and `ext_op` are held at their EXEC values.
  - The FSM holds in MEM until `mem_ready`.
  - On `mem_ready`, `lw` goes to WB and `sw` goes to FETCH.
- **WB:**
  - `reg_write`=1.
  - `lw`: `reg_dst`=0, `wd_sel`=1.
  - R-type: `reg_dst`=1, `wd_sel`=0.
  - `ori`/`lui`/`addiu`: `reg_dst`=0, `wd_sel`=0.
  - Next state FETCH.
- **TRAP:**
  - `illegal`=1.
  - All enables and strobes are 0.
  - The FSM stays in TRAP until `rst`.
- **Default:** any output not listed for a state is 0.

## Timing
- **Reset:**
  - While `rst`=1, every output is forced to 0, including the `mem_read` strobe.
  - The edge with `rst`=1 sets `state` to FETCH.
  - `rst` has priority over every transition, including mid-MEM, mid-FETCH stall and TRAP. Partially completed instructions are abandoned with no write.
- **Cycle counts with `mem_ready` tied high:**
  - R-type, `ori`, `lui`, `addiu`: 4
  - `lw`: 5
  - `sw`: 4
  - `beq`: 3
  - `j`, `jal`, `jr`, `nop`: 2
- **Memory waits:** each cycle `mem_ready`=0 in FETCH or MEM adds exactly one cycle. Strobes stay asserted and stable throughout the wait.
- **Write enables:** `pc_write` and `ir_write` are asserted only in the single cycle where they take effect. `reg_write` is asserted exactly one cycle per writing instruction.
- **Branch decision:** `beq` samples `zero` in EXEC only.
- **Unreachable encodings:** states 5 and 6 go to TRAP on the next edge.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `mem_ready`=1, then release.
  - Response: all outputs 0 while `rst`=1. `state` is 0 after the first reset edge. The cycle after release shows `mem_read`=1, `ir_write`=1, `pc_write`=1.
- **Instruction sequence:**
  - Stimulus: `addu` (0x00851021), `ori` (0x34a5ffff), `lw` (0x8c880004), `sw` (0xac880008), `mem_ready`=1.
  - Response: exactly 4/4/5/4 cycles per instruction. WB values: `reg_dst`=1/0/0, `wd_sel`=0/0/1. `ext_op`=0 for `ori`. `sw` asserts `mem_write` for 1 cycle and never `reg_write`.
- **Branch and jumps:**
  - Stimulus: `beq` (0x10850003) with `zero`=1, then `beq` with `zero`=0, then `jal` (0x0c000010), then `jr` (0x03e00008).
  - Response: `pc_write`=1 with `npc_sel`=1 for the first `beq`; `pc_write`=0 in EXEC for the second. `jal` produces `reg_write`=1, `reg_dst`=2, `wd_sel`=2, `npc_sel`=2 in DECODE. `jr` produces `npc_sel`=3.
- **Memory stalls:**
  - Stimulus: `lw` with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEM.
  - Response: total 10 cycles. `mem_read` is continuously high in both waits. There is exactly one `ir_write` pulse and one `reg_write` pulse.
- **Illegal and EXT_ISA=0:**
  - Stimulus: opcode 0x3f; separately, `addiu` (0x24420001) with EXT_ISA=0.
  - Response: DECODE moves to TRAP with `illegal`=1, held for 20+ cycles with no enables asserted. `rst` returns `state` to 0.
- **Reset mid-operation:**
  - Stimulus: assert `rst` while in MEM for `sw` with `mem_ready`=0.
  - Response: `mem_write` drops the same cycle, no write occurs, and the next state is FETCH.
